// File: rtl/a23_copro_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : a23_copro_init_seq
// Description : Boot-time CP15 programming sequencer: flush, program cache
//               regions, verify ID and readbacks, then enable the cache.
// Revision    : 1.0
// ============================================================================
module a23_copro_init_seq #(
    parameter logic [31:0] P_ID = 32'h4156_0300
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_fetch_stall,
    input  logic [2:0]  i_cfg_cache_control,
    input  logic [31:0] i_cfg_cacheable,
    input  logic [31:0] i_cfg_updateable,
    input  logic [31:0] i_cfg_disruptive,
    input  logic [31:0] i_copro_read_data,
    output logic [1:0]  o_copro_operation,
    output logic [3:0]  o_copro_crn,
    output logic [31:0] o_copro_write_data,
    output logic [3:0]  o_copro_num,
    output logic [2:0]  o_copro_opcode1,
    output logic [2:0]  o_copro_opcode2,
    output logic [3:0]  o_copro_crm,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [3:0]  o_err_crn
);

    localparam logic [1:0] c_op_none = 2'd0;
    localparam logic [1:0] c_op_mrc  = 2'd1;
    localparam logic [1:0] c_op_mcr  = 2'd2;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'd0,
        ST_LOAD  = 5'd1,
        ST_FLUSH = 5'd2,
        ST_WR3   = 5'd3,
        ST_WR4   = 5'd4,
        ST_WR5   = 5'd5,
        ST_RD0   = 5'd6,
        ST_CK0   = 5'd7,
        ST_RD3   = 5'd8,
        ST_CK3   = 5'd9,
        ST_RD4   = 5'd10,
        ST_CK4   = 5'd11,
        ST_RD5   = 5'd12,
        ST_CK5   = 5'd13,
        ST_WR2   = 5'd14,
        ST_DONE  = 5'd15,
        ST_ERROR = 5'd16
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cache_control_q, cache_control_d;
    logic [31:0] cacheable_q, cacheable_d;
    logic [31:0] updateable_q, updateable_d;
    logic [31:0] disruptive_q, disruptive_d;
    logic [3:0]  err_crn_q, err_crn_d;

    logic        adv;
    logic        chk_en;
    logic [31:0] chk_exp;
    state_t      chk_next;

    assign adv = ~i_fetch_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= ST_IDLE;
            cache_control_q <= 3'd0;
            cacheable_q     <= 32'd0;
            updateable_q    <= 32'd0;
            disruptive_q    <= 32'd0;
            err_crn_q       <= 4'd0;
        end else begin
            state_q         <= state_d;
            cache_control_q <= cache_control_d;
            cacheable_q     <= cacheable_d;
            updateable_q    <= updateable_d;
            disruptive_q    <= disruptive_d;
            err_crn_q       <= err_crn_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cache_control_d    = cache_control_q;
        cacheable_d        = cacheable_q;
        updateable_d       = updateable_q;
        disruptive_d       = disruptive_q;
        err_crn_d          = err_crn_q;
        o_copro_operation  = c_op_none;
        o_copro_crn        = 4'd0;
        o_copro_write_data = 32'd0;
        chk_en             = 1'b0;
        chk_exp            = 32'd0;
        chk_next           = ST_ERROR;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // Config is snapshotted here so the running sequence is immune to later changes
                if (i_start && adv) begin
                    state_d         = ST_LOAD;
                    cache_control_d = i_cfg_cache_control;
                    cacheable_d     = i_cfg_cacheable;
                    updateable_d    = i_cfg_updateable;
                    disruptive_d    = i_cfg_disruptive;
                    err_crn_d       = 4'd0;
                end
            end
            ST_LOAD: begin
                if (adv) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                o_copro_operation = c_op_mcr;
                o_copro_crn       = 4'd1;
                if (adv) state_d = ST_WR3;
            end
            ST_WR3: begin
                o_copro_operation  = c_op_mcr;
                o_copro_crn        = 4'd3;
                o_copro_write_data = cacheable_q;
                if (adv) state_d = ST_WR4;
            end
            ST_WR4: begin
                o_copro_operation  = c_op_mcr;
                o_copro_crn        = 4'd4;
                o_copro_write_data = updateable_q;
                if (adv) state_d = ST_WR5;
            end
            ST_WR5: begin
                o_copro_operation  = c_op_mcr;
                o_copro_crn        = 4'd5;
                o_copro_write_data = disruptive_q;
                if (adv) state_d = ST_RD0;
            end
            ST_RD0: begin
                o_copro_operation = c_op_mrc;
                o_copro_crn       = 4'd0;
                if (adv) state_d = ST_CK0;
            end
            ST_CK0: begin
                o_copro_crn = 4'd0;
                chk_en      = 1'b1;
                chk_exp     = P_ID;
                chk_next    = ST_RD3;
            end
            ST_RD3: begin
                o_copro_operation = c_op_mrc;
                o_copro_crn       = 4'd3;
                if (adv) state_d = ST_CK3;
            end
            ST_CK3: begin
                o_copro_crn = 4'd3;
                chk_en      = 1'b1;
                chk_exp     = cacheable_q;
                chk_next    = ST_RD4;
            end
            ST_RD4: begin
                o_copro_operation = c_op_mrc;
                o_copro_crn       = 4'd4;
                if (adv) state_d = ST_CK4;
            end
            ST_CK4: begin
                o_copro_crn = 4'd4;
                chk_en      = 1'b1;
                chk_exp     = updateable_q;
                chk_next    = ST_RD5;
            end
            ST_RD5: begin
                o_copro_operation = c_op_mrc;
                o_copro_crn       = 4'd5;
                if (adv) state_d = ST_CK5;
            end
            ST_CK5: begin
                o_copro_crn = 4'd5;
                chk_en      = 1'b1;
                chk_exp     = disruptive_q;
                chk_next    = ST_WR2;
            end
            ST_WR2: begin
                o_copro_operation  = c_op_mcr;
                o_copro_crn        = 4'd2;
                o_copro_write_data = {29'd0, cache_control_q};
                if (adv) state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A failed readback parks in ERROR before the cache-enable write is ever issued
        if (chk_en && adv) begin
            if (i_copro_read_data != chk_exp) begin
                state_d   = ST_ERROR;
                err_crn_d = o_copro_crn;
            end else begin
                state_d   = chk_next;
            end
        end
    end

    assign o_copro_num     = 4'd15;
    assign o_copro_opcode1 = 3'd0;
    assign o_copro_opcode2 = 3'd0;
    assign o_copro_crm     = 4'd0;

    assign o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign o_done    = (state_q == ST_DONE);
    assign o_error   = (state_q == ST_ERROR);
    assign o_err_crn = err_crn_q;

endmodule
`default_nettype wire

// File: tb/tb_a23_copro_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_a23_copro_init_seq
// Description : Directed bench for the CP15 init sequencer with a small
//               CP15 responder model.
// Revision    : 1.0
// ============================================================================
module tb_a23_copro_init_seq;

    localparam logic [31:0] c_id = 32'h4156_0300;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic [2:0]  cfg_ctrl;
    logic [31:0] cfg_cach, cfg_upd, cfg_dis;
    logic [31:0] rd_data;
    logic [1:0]  op;
    logic [3:0]  crn;
    logic [31:0] wd;
    logic [3:0]  num, crm;
    logic [2:0]  opc1, opc2;
    logic        busy, done, error;
    logic [3:0]  err_crn;

    always #5 clk = ~clk;

    a23_copro_init_seq #(.P_ID(c_id)) u_dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_start             (start),
        .i_fetch_stall       (stall),
        .i_cfg_cache_control (cfg_ctrl),
        .i_cfg_cacheable     (cfg_cach),
        .i_cfg_updateable    (cfg_upd),
        .i_cfg_disruptive    (cfg_dis),
        .i_copro_read_data   (rd_data),
        .o_copro_operation   (op),
        .o_copro_crn         (crn),
        .o_copro_write_data  (wd),
        .o_copro_num         (num),
        .o_copro_opcode1     (opc1),
        .o_copro_opcode2     (opc2),
        .o_copro_crm         (crm),
        .o_busy              (busy),
        .o_done              (done),
        .o_error             (error),
        .o_err_crn           (err_crn)
    );

    // CP15 responder model
    logic [31:0] cp2, cp3, cp4, cp5;
    bit          id_bad, flip4;
    int          flush_cnt = 0, wr2_cnt = 0, wr4_cnt = 0, wr_cnt = 0, rd_cnt = 0;

    function automatic logic [31:0] model_read(input logic [3:0] n);
        case (n)
            4'd0:    model_read = id_bad ? 32'h4156_0301 : c_id;
            4'd3:    model_read = cp3;
            4'd4:    model_read = cp4 ^ (flip4 ? 32'h0000_0010 : 32'h0);
            4'd5:    model_read = cp5;
            default: model_read = 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cp2 <= 0; cp3 <= 0; cp4 <= 0; cp5 <= 0; rd_data <= 0;
        end else if (!stall) begin
            if (op == 2'd2) begin
                case (crn)
                    4'd2: cp2 <= wd;
                    4'd3: cp3 <= wd;
                    4'd4: cp4 <= wd;
                    4'd5: cp5 <= wd;
                    default: ;
                endcase
            end
            if (op == 2'd1) rd_data <= model_read(crn);
        end
    end

    always @(posedge clk) begin
        if (!rst && !stall) begin
            if (op == 2'd2) begin
                wr_cnt <= wr_cnt + 1;
                if (crn == 4'd1) flush_cnt <= flush_cnt + 1;
                if (crn == 4'd2) wr2_cnt <= wr2_cnt + 1;
                if (crn == 4'd4) wr4_cnt <= wr4_cnt + 1;
            end
            if (op == 2'd1) rd_cnt <= rd_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_nominal_cfg();
        cfg_cach = 32'h0000_0003;
        cfg_upd  = 32'h0000_0001;
        cfg_dis  = 32'h0000_0000;
        cfg_ctrl = 3'b001;
    endtask

    // Pulses start, then counts edges after the accepting edge until done/error
    task automatic run_seq(input int wr4_st, input int ck3_st, input bit disturb, output int edges);
        int wr4_left;
        int ck3_left;
        wr4_left = wr4_st;
        ck3_left = ck3_st;
        edges = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            stall = 1'b0;
            if (wr4_left > 0 && op == 2'd2 && crn == 4'd4) begin
                stall = 1'b1;
                wr4_left--;
            end else if (ck3_left > 0 && busy && op == 2'd0 && crn == 4'd3) begin
                stall = 1'b1;
                ck3_left--;
            end
            if (disturb) begin
                start = (n == 5);
                if (n == 2) begin
                    cfg_cach = 32'hFFFF_0000;
                    cfg_upd  = 32'h0000_00F0;
                    cfg_dis  = 32'h1234_5678;
                    cfg_ctrl = 3'b110;
                end
            end
            @(posedge clk);
            #1;
            if (done || error) begin
                edges = n;
                break;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        set_nominal_cfg();
        if (edges == 0) chk("seq_timeout", 32'd0, 32'd1);
    endtask

    int edges;
    int s_fl, s_w2, s_w4, s_wr, s_rd, s_acc;

    task automatic snap();
        s_fl = flush_cnt; s_w2 = wr2_cnt; s_w4 = wr4_cnt; s_wr = wr_cnt; s_rd = rd_cnt;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; id_bad = 0; flip4 = 0;
        set_nominal_cfg();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op", {30'd0, op}, 32'd0);
        chk("rst_crn", {28'd0, crn}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_errcrn", {28'd0, err_crn}, 32'd0);
        chk("const_num", {28'd0, num}, 32'd15);
        @(negedge clk);
        rst = 1'b0;

        // Nominal with busy-time start pulse and cfg changes after acceptance
        snap();
        run_seq(0, 0, 1'b1, edges);
        chk("nom_edges", edges, 32'd14);
        chk("nom_done", {31'd0, done}, 32'd1);
        chk("nom_busy", {31'd0, busy}, 32'd0);
        chk("nom_error", {31'd0, error}, 32'd0);
        chk("nom_cache_en", cp2, 32'd1);
        chk("nom_cacheable", cp3, 32'd3);
        chk("nom_updateable", cp4, 32'd1);
        chk("nom_flush", flush_cnt - s_fl, 32'd1);
        chk("nom_wr2", wr2_cnt - s_w2, 32'd1);
        chk("nom_wr", wr_cnt - s_wr, 32'd5);
        chk("nom_rd", rd_cnt - s_rd, 32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("nom_idle_after", {31'd0, busy}, 32'd0);

        // Stalls in WR4 and CK3
        snap();
        run_seq(3, 2, 1'b0, edges);
        chk("stl_edges", edges, 32'd19);
        chk("stl_done", {31'd0, done}, 32'd1);
        chk("stl_wr4", wr4_cnt - s_w4, 32'd1);
        chk("stl_wr", wr_cnt - s_wr, 32'd5);
        chk("stl_rd", rd_cnt - s_rd, 32'd4);
        chk("stl_flush", flush_cnt - s_fl, 32'd1);

        // ID mismatch
        id_bad = 1;
        snap();
        run_seq(0, 0, 1'b0, edges);
        chk("id_edges", edges, 32'd7);
        chk("id_error", {31'd0, error}, 32'd1);
        chk("id_done", {31'd0, done}, 32'd0);
        chk("id_errcrn", {28'd0, err_crn}, 32'd0);
        chk("id_wr2", wr2_cnt - s_w2, 32'd0);
        chk("id_rd", rd_cnt - s_rd, 32'd1);
        id_bad = 0;

        // Restart from ERROR
        run_seq(0, 0, 1'b0, edges);
        chk("rs_edges", edges, 32'd14);
        chk("rs_done", {31'd0, done}, 32'd1);
        chk("rs_error", {31'd0, error}, 32'd0);

        // Async reset between edges while RD3 is on the bus
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (op == 2'd1 && crn == 4'd3) begin
                edges = n;
                break;
            end
        end
        chk("ar_reach_rd3", edges, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_op", {30'd0, op}, 32'd0);
        chk("ar_crn", {28'd0, crn}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        s_acc = wr_cnt + rd_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ar_no_access", wr_cnt + rd_cnt - s_acc, 32'd0);
        chk("ar_stay_idle", {31'd0, busy}, 32'd0);

        // Readback bit flip on crn4
        flip4 = 1;
        snap();
        run_seq(0, 0, 1'b0, edges);
        chk("fl_edges", edges, 32'd11);
        chk("fl_error", {31'd0, error}, 32'd1);
        chk("fl_errcrn", {28'd0, err_crn}, 32'd4);
        chk("fl_cache_en", cp2, 32'd0);
        chk("fl_wr2", wr2_cnt - s_w2, 32'd0);
        flip4 = 0;

        run_seq(0, 0, 1'b0, edges);
        chk("fin_done", {31'd0, done}, 32'd1);
        chk("fin_errcrn", {28'd0, err_crn}, 32'd0);
        chk("fin_cache_en", cp2, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
